// File: rtl/axi4l_up_master.sv
// up_wr/up_rd request port driving a single-outstanding AXI4-Lite master.
// Optional macro AXI4L_UP_MASTER_ERR_EN adds up_wr_err/up_rd_err response flags.
module axi4l_up_master #(
    parameter int unsigned C_ADDR_WIDTH = 12,
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter logic [31:0] C_BASE_ADDR  = 32'h0000_0000
) (
    input  logic                      aclk,
    input  logic                      areset,

    input  logic [C_ADDR_WIDTH-3:0]   up_wr_addr,
    input  logic                      up_wr_req,
    input  logic [3:0]                up_wr_be,
    input  logic [C_DATA_WIDTH-1:0]   up_wr_din,
    output logic                      up_wr_ack,
    input  logic [C_ADDR_WIDTH-3:0]   up_rd_addr,
    input  logic                      up_rd_req,
    output logic [C_DATA_WIDTH-1:0]   up_rd_dout,
    output logic                      up_rd_ack,
`ifdef AXI4L_UP_MASTER_ERR_EN
    output logic                      up_wr_err,
    output logic                      up_rd_err,
`endif

    output logic [31:0]               m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [3:0]                m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [31:0]               m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;

    state_t                    r_state;
    logic                      r_wr_pend;
    logic                      r_rd_pend;
    logic [C_ADDR_WIDTH-3:0]   r_wr_addr_h;
    logic [3:0]                r_wr_be_h;
    logic [C_DATA_WIDTH-1:0]   r_wr_din_h;
    logic [C_ADDR_WIDTH-3:0]   r_rd_addr_h;
    logic                      r_aw_done;
    logic                      r_w_done;

    logic                      w_idle;
    logic                      w_wr_avail;
    logic                      w_rd_avail;
    logic                      w_wr_launch;
    logic                      w_rd_launch;
    logic [C_ADDR_WIDTH-3:0]   w_wr_addr_sel;
    logic [3:0]                w_wr_be_sel;
    logic [C_DATA_WIDTH-1:0]   w_wr_din_sel;
    logic [C_ADDR_WIDTH-3:0]   w_rd_addr_sel;
    logic [31:0]               w_awaddr;
    logic [31:0]               w_araddr;
    logic                      w_aw_fire;
    logic                      w_w_fire;
    logic                      w_b_fire;
    logic                      w_ar_fire;
    logic                      w_r_fire;
    logic                      w_aw_done;
    logic                      w_w_done;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    // A fresh req is visible to IDLE in its own cycle so a zero-wait write/read acks at cycle 3.
    assign w_idle      = (r_state == S_IDLE);
    assign w_wr_avail  = r_wr_pend | up_wr_req;
    assign w_rd_avail  = r_rd_pend | up_rd_req;
    assign w_wr_launch = w_idle & w_wr_avail;
    assign w_rd_launch = w_idle & ~w_wr_avail & w_rd_avail;

    assign w_wr_addr_sel = r_wr_pend ? r_wr_addr_h : up_wr_addr;
    assign w_wr_be_sel   = r_wr_pend ? r_wr_be_h   : up_wr_be;
    assign w_wr_din_sel  = r_wr_pend ? r_wr_din_h  : up_wr_din;
    assign w_rd_addr_sel = r_rd_pend ? r_rd_addr_h : up_rd_addr;
    assign w_awaddr      = C_BASE_ADDR | 32'({w_wr_addr_sel, 2'b00});
    assign w_araddr      = C_BASE_ADDR | 32'({w_rd_addr_sel, 2'b00});

    assign w_aw_fire = m_axi_awvalid & m_axi_awready;
    assign w_w_fire  = m_axi_wvalid  & m_axi_wready;
    assign w_b_fire  = m_axi_bvalid  & m_axi_bready;
    assign w_ar_fire = m_axi_arvalid & m_axi_arready;
    assign w_r_fire  = m_axi_rvalid  & m_axi_rready;
    assign w_aw_done = r_aw_done | w_aw_fire;
    assign w_w_done  = r_w_done  | w_w_fire;

`ifndef AXI4L_UP_MASTER_ERR_EN
    logic w_unused_resp;
    assign w_unused_resp = ^{m_axi_bresp, m_axi_rresp};
`endif

    // Holding registers: a req is accepted when nothing is pending or the pending one launches now.
    always_ff @(posedge aclk) begin
        if (up_wr_req && (!r_wr_pend || w_wr_launch)) begin
            r_wr_addr_h <= up_wr_addr;
            r_wr_be_h   <= up_wr_be;
            r_wr_din_h  <= up_wr_din;
        end
        if (up_rd_req && (!r_rd_pend || w_rd_launch)) begin
            r_rd_addr_h <= up_rd_addr;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
        end else begin
            if (w_wr_launch) begin
                r_wr_pend <= r_wr_pend & up_wr_req;
            end else if (up_wr_req) begin
                r_wr_pend <= 1'b1;
            end
            if (w_rd_launch) begin
                r_rd_pend <= r_rd_pend & up_rd_req;
            end else if (up_rd_req) begin
                r_rd_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= S_IDLE;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_araddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            up_wr_ack     <= 1'b0;
            up_rd_ack     <= 1'b0;
            up_rd_dout    <= '0;
`ifdef AXI4L_UP_MASTER_ERR_EN
            up_wr_err     <= 1'b0;
            up_rd_err     <= 1'b0;
`endif
        end else begin
            up_wr_ack <= 1'b0;
            up_rd_ack <= 1'b0;
`ifdef AXI4L_UP_MASTER_ERR_EN
            up_wr_err <= 1'b0;
            up_rd_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_wr_launch) begin
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        m_axi_awaddr  <= w_awaddr;
                        m_axi_wdata   <= w_wr_din_sel;
                        m_axi_wstrb   <= w_wr_be_sel;
                        r_aw_done     <= 1'b0;
                        r_w_done      <= 1'b0;
                        r_state       <= S_WR_ADDR;
                    end else if (w_rd_launch) begin
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= w_araddr;
                        r_state       <= S_RD_ADDR;
                    end
                end
                // AW and W channels complete independently; response phase waits for both.
                S_WR_ADDR: begin
                    if (w_aw_fire) begin
                        m_axi_awvalid <= 1'b0;
                        r_aw_done     <= 1'b1;
                    end
                    if (w_w_fire) begin
                        m_axi_wvalid <= 1'b0;
                        r_w_done     <= 1'b1;
                    end
                    if (w_aw_done && w_w_done) begin
                        m_axi_bready <= 1'b1;
                        r_state      <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (w_b_fire) begin
                        m_axi_bready <= 1'b0;
                        up_wr_ack    <= 1'b1;
`ifdef AXI4L_UP_MASTER_ERR_EN
                        up_wr_err    <= |m_axi_bresp;
`endif
                        r_state      <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (w_ar_fire) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        r_state       <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (w_r_fire) begin
                        m_axi_rready <= 1'b0;
                        up_rd_dout   <= m_axi_rdata;
                        up_rd_ack    <= 1'b1;
`ifdef AXI4L_UP_MASTER_ERR_EN
                        up_rd_err    <= |m_axi_rresp;
`endif
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l_up_master.sv
// Directed bench for axi4l_up_master: cycle-vector table plus hand-written corner sequences.
// Error flag checks are compiled only when AXI4L_UP_MASTER_ERR_EN is defined.
module tb_axi4l_up_master;

    logic        aclk;
    logic        areset;
    logic [9:0]  up_wr_addr;
    logic        up_wr_req;
    logic [3:0]  up_wr_be;
    logic [31:0] up_wr_din;
    logic        up_wr_ack;
    logic [9:0]  up_rd_addr;
    logic        up_rd_req;
    logic [31:0] up_rd_dout;
    logic        up_rd_ack;
`ifdef AXI4L_UP_MASTER_ERR_EN
    logic        up_wr_err;
    logic        up_rd_err;
`endif
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    axi4l_up_master #(
        .C_ADDR_WIDTH (12),
        .C_DATA_WIDTH (32),
        .C_BASE_ADDR  (32'h4000_0000)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .up_wr_addr    (up_wr_addr),
        .up_wr_req     (up_wr_req),
        .up_wr_be      (up_wr_be),
        .up_wr_din     (up_wr_din),
        .up_wr_ack     (up_wr_ack),
        .up_rd_addr    (up_rd_addr),
        .up_rd_req     (up_rd_req),
        .up_rd_dout    (up_rd_dout),
        .up_rd_ack     (up_rd_ack),
`ifdef AXI4L_UP_MASTER_ERR_EN
        .up_wr_err     (up_wr_err),
        .up_rd_err     (up_rd_err),
`endif
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Handshake / ack counters sampled mid-cycle.
    int   n_aw;
    int   n_wack;
    int   n_rack;
    logic mon_clr;
    always @(negedge aclk) begin
        if (mon_clr) begin
            n_aw   <= 0;
            n_wack <= 0;
            n_rack <= 0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) n_aw <= n_aw + 1;
            if (up_wr_ack) n_wack <= n_wack + 1;
            if (up_rd_ack) n_rack <= n_rack + 1;
        end
    end

    // {awvalid, wvalid, bready, arvalid, rready, up_wr_ack, up_rd_ack}
    function automatic logic [6:0] outs();
        return {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                m_axi_rready, up_wr_ack, up_rd_ack};
    endfunction

    typedef struct {
        logic        wreq;
        logic        rreq;
        logic        bvld;
        logic        rvld;
        logic [31:0] rdata;
        logic [6:0]  exp;
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wreq, input logic rreq, input logic bvld,
                                input logic rvld, input logic [31:0] rdata,
                                input logic [6:0] e, input logic [31:0] d,
                                input logic [31:0] a);
        vec_t v;
        v.wreq = wreq; v.rreq = rreq; v.bvld = bvld; v.rvld = rvld;
        v.rdata = rdata; v.exp = e; v.exp_data = d; v.exp_addr = a;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge aclk);
        #1;
        mon_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        areset = 1'b1;  mon_clr = 1'b1;
        up_wr_addr = '0; up_wr_req = 1'b0; up_wr_be = '0; up_wr_din = '0;
        up_rd_addr = '0; up_rd_req = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b0;
        repeat (3) tick();

        chk("reset outs", 32'(outs()), 32'h0);
        chk("reset dout", up_rd_dout, 32'h0);
        chk("reset awaddr", m_axi_awaddr, 32'h0);
        chk("reset araddr", m_axi_araddr, 32'h0);
        chk("prot", 32'({m_axi_awprot, m_axi_arprot}), 32'h0);
        areset = 1'b0;
        mon_clr = 1'b0;
        tick();

        // Zero-wait write (rows 0-4), then simultaneous wr+rd (rows 5-12).
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,         7'b0000000, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         7'b1100000, 32'hDEADBEEF, 32'h4000_0010));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         7'b0010000, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         7'b0000010, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         7'b0000000, 32'h0,         32'h0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         7'b0000000, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         7'b1100000, 32'hDEADBEEF, 32'h4000_0010));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         7'b0010000, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         7'b0000010, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         7'b0001000, 32'h0,         32'h4000_0554));
        vecs.push_back(mk(0, 0, 0, 1, 32'hCAFEF00D,  7'b0000100, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         7'b0000001, 32'hCAFEF00D,  32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         7'b0000000, 32'h0,         32'h0));

        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        up_wr_addr = 10'h004; up_wr_din = 32'hDEADBEEF; up_wr_be = 4'hF;
        up_rd_addr = 10'h155;
        for (int i = 0; i < vecs.size(); i++) begin
            chk($sformatf("vec%0d outs", i), 32'(outs()), 32'(vecs[i].exp));
            if (vecs[i].exp[6]) begin
                chk($sformatf("vec%0d awaddr", i), m_axi_awaddr, vecs[i].exp_addr);
                chk($sformatf("vec%0d wdata", i), m_axi_wdata, vecs[i].exp_data);
                chk($sformatf("vec%0d wstrb", i), 32'(m_axi_wstrb), 32'hF);
            end
            if (vecs[i].exp[3]) chk($sformatf("vec%0d araddr", i), m_axi_araddr, vecs[i].exp_addr);
            if (vecs[i].exp[0]) chk($sformatf("vec%0d dout", i), up_rd_dout, vecs[i].exp_data);
            up_wr_req    = vecs[i].wreq;
            up_rd_req    = vecs[i].rreq;
            m_axi_bvalid = vecs[i].bvld;
            m_axi_rvalid = vecs[i].rvld;
            m_axi_rdata  = vecs[i].rdata;
            tick();
        end
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;

        // Backpressured write: W accepted at once, AW held off until cycle 5.
        clr_mon();
        tick();
        up_wr_addr = 10'h020; up_wr_din = 32'h55AA33CC; up_wr_be = 4'hA; up_wr_req = 1'b1;
        m_axi_wready = 1'b1;
        tick();
        up_wr_req = 1'b0;
        chk("bp c1 valids", 32'({m_axi_awvalid, m_axi_wvalid}), 32'h3);
        chk("bp c1 wstrb", 32'(m_axi_wstrb), 32'hA);
        tick();
        for (int c = 2; c <= 4; c++) begin
            chk($sformatf("bp c%0d valids", c), 32'({m_axi_awvalid, m_axi_wvalid}), 32'h2);
            chk($sformatf("bp c%0d awaddr", c), m_axi_awaddr, 32'h4000_0080);
            tick();
        end
        chk("bp c5 awvalid", 32'(m_axi_awvalid), 32'h1);
        m_axi_awready = 1'b1;
        tick();
        m_axi_awready = 1'b0;
        chk("bp c6 outs", 32'(outs()), 32'(7'b0010000));
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        chk("bp c7 wr_ack", 32'(up_wr_ack), 32'h1);
        tick();
        chk("bp c8 wr_ack", 32'(up_wr_ack), 32'h0);
        chk("bp ack count", n_wack, 1);
        chk("bp aw beats", n_aw, 1);
        m_axi_wready = 1'b0;

        // Read with three wait cycles before rvalid.
        clr_mon();
        tick();
        m_axi_arready = 1'b1; up_rd_addr = 10'h3FF; up_rd_req = 1'b1;
        tick();
        up_rd_req = 1'b0;
        chk("rd c1 arvalid", 32'(m_axi_arvalid), 32'h1);
        chk("rd c1 araddr", m_axi_araddr, 32'h4000_0FFC);
        tick();
        for (int c = 2; c <= 4; c++) begin
            chk($sformatf("rd c%0d outs", c), 32'(outs()), 32'(7'b0000100));
            tick();
        end
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1234_5678;
        chk("rd c5 rready", 32'(m_axi_rready), 32'h1);
        tick();
        m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        chk("rd c6 rd_ack", 32'(up_rd_ack), 32'h1);
        chk("rd c6 dout", up_rd_dout, 32'h1234_5678);
        tick();
        chk("rd c7 rd_ack", 32'(up_rd_ack), 32'h0);
        chk("rd ack count", n_rack, 1);
        m_axi_arready = 1'b0;

        // Overflow: second write req while the first is still pending behind a stalled read.
        clr_mon();
        tick();
        up_rd_addr = 10'h010; up_rd_req = 1'b1;
        tick();
        up_rd_req = 1'b0;
        tick();
        up_wr_addr = 10'h0C0; up_wr_din = 32'hA1A1A1A1; up_wr_be = 4'hF; up_wr_req = 1'b1;
        tick();
        up_wr_addr = 10'h0F0; up_wr_din = 32'hB2B2B2B2; up_wr_req = 1'b1;
        tick();
        up_wr_req = 1'b0; m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        chk("ovf c5 rready", 32'(m_axi_rready), 32'h1);
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0000_0077;
        tick();
        m_axi_rvalid = 1'b0;
        chk("ovf c6 rd_ack", 32'(up_rd_ack), 32'h1);
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        tick();
        chk("ovf c7 awvalid", 32'(m_axi_awvalid), 32'h1);
        chk("ovf c7 awaddr", m_axi_awaddr, 32'h4000_0300);
        chk("ovf c7 wdata", m_axi_wdata, 32'hA1A1A1A1);
        tick();
        chk("ovf c8 bready", 32'(m_axi_bready), 32'h1);
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        chk("ovf c9 wr_ack", 32'(up_wr_ack), 32'h1);
        repeat (4) tick();
        chk("ovf aw beats", n_aw, 1);
        chk("ovf ack count", n_wack, 1);

        // Reset while waiting in the write response phase.
        clr_mon();
        tick();
        up_wr_addr = 10'h004; up_wr_din = 32'hDEADBEEF; up_wr_req = 1'b1;
        tick();
        up_wr_req = 1'b0;
        tick();
        chk("rst c2 bready", 32'(m_axi_bready), 32'h1);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chk("rst c3 outs", 32'(outs()), 32'h0);
        chk("rst c3 dout", up_rd_dout, 32'h0);
        chk("rst c3 awaddr", m_axi_awaddr, 32'h0);
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        chk("rst c4 outs", 32'(outs()), 32'h0);
        repeat (2) tick();
        chk("rst ack count", n_wack, 0);

        // SLVERR write response followed by an OKAY read.
        clr_mon();
        tick();
        up_wr_req = 1'b1;
        tick();
        up_wr_req = 1'b0;
        tick();
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
        tick();
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        chk("err wr_ack", 32'(up_wr_ack), 32'h1);
`ifdef AXI4L_UP_MASTER_ERR_EN
        chk("err wr_err", 32'(up_wr_err), 32'h1);
`endif
        up_rd_addr = 10'h001; up_rd_req = 1'b1; m_axi_arready = 1'b1;
        tick();
        up_rd_req = 1'b0;
        chk("err c4 arvalid", 32'(m_axi_arvalid), 32'h1);
        chk("err c4 araddr", m_axi_araddr, 32'h4000_0004);
`ifdef AXI4L_UP_MASTER_ERR_EN
        chk("err c4 wr_err", 32'(up_wr_err), 32'h0);
`endif
        tick();
        chk("err c5 rready", 32'(m_axi_rready), 32'h1);
        m_axi_rvalid = 1'b1; m_axi_rresp = 2'b00; m_axi_rdata = 32'h0000_0009;
        tick();
        m_axi_rvalid = 1'b0;
        chk("err rd_ack", 32'(up_rd_ack), 32'h1);
        chk("err rd dout", up_rd_dout, 32'h0000_0009);
`ifdef AXI4L_UP_MASTER_ERR_EN
        chk("err rd_err", 32'(up_rd_err), 32'h0);
`endif
        tick();
        chk("err ack counts", 32'({n_wack[15:0], n_rack[15:0]}), 32'h0001_0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
